// File: rtl/sram_controller_multibeat.sv
// Word-wide access to a narrow async SRAM, split into BEATS beats of BEAT_CYCLES clocks each (MS slice first).
// Optional byte-masked writes are compiled in when the macro SRAM_BYTE_MASK_EN is defined.
module sram_controller_multibeat #(
  parameter int          DATA_WIDTH      = 32,
  parameter int          SRAM_WIDTH      = 16,
  parameter int          ADDR_WIDTH      = 32,
  parameter int          SRAM_ADDR_WIDTH = 18,
  parameter int          BEAT_CYCLES     = 2,
  parameter int unsigned BASE_ADDR       = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       read_enable,
  input  logic                       write_enable,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic [DATA_WIDTH-1:0]      write_data,
`ifdef SRAM_BYTE_MASK_EN
  input  logic [DATA_WIDTH/8-1:0]    byte_en,
`endif
  output logic [DATA_WIDTH-1:0]      read_data,
  output logic                       done,
  output logic                       ready,
  inout  wire  [SRAM_WIDTH-1:0]      SRAM_DQ,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic                       SRAM_UB_N,
  output logic                       SRAM_LB_N,
  output logic                       SRAM_WE_N,
  output logic                       SRAM_CE_N,
  output logic                       SRAM_OE_N
);

  localparam int BEATS = DATA_WIDTH / SRAM_WIDTH;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = 4;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] LAST_CYC  = CW'(BEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e                     state_q, state_d;
  logic [BW-1:0]              beat_q, beat_d;
  logic [CW-1:0]              cyc_q, cyc_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
`ifdef SRAM_BYTE_MASK_EN
  logic [BYTES-1:0]           mask_q, mask_d;
  logic [1:0]                 beat_mask;
`endif

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [BW-1:0]         slice_idx;
  logic                  beat_end;
  logic                  dq_oe;
  logic [SRAM_WIDTH-1:0] dq_out;

  // Relocate by BASE_ADDR first so unaligned offsets round down within the SRAM window.
  assign word_idx  = (address - ADDR_WIDTH'(BASE_ADDR)) >> OFFS;
  assign slice_idx = LAST_BEAT - beat_q;
  assign beat_end  = (cyc_q == LAST_CYC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      cyc_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef SRAM_BYTE_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef SRAM_BYTE_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (read_enable)       state_d = READ;
        else if (write_enable) state_d = WRITE;
      end
      READ, WRITE: begin
        if (beat_end && beat_q == LAST_BEAT) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    beat_d  = beat_q;
    cyc_d   = cyc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef SRAM_BYTE_MASK_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      IDLE: begin
        beat_d = '0;
        cyc_d  = '0;
        if (read_enable || write_enable) begin
          addr_d  = SRAM_ADDR_WIDTH'(word_idx * ADDR_WIDTH'(BEATS));
          wdata_d = write_data;
`ifdef SRAM_BYTE_MASK_EN
          mask_d  = byte_en;
`endif
        end
      end
      READ, WRITE: begin
        if (state_q == READ && beat_end)
          rdata_d[slice_idx*SRAM_WIDTH +: SRAM_WIDTH] = SRAM_DQ;
        if (beat_end) begin
          cyc_d = '0;
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
          end else begin
            beat_d = beat_q + BW'(1);
            addr_d = addr_q + SRAM_ADDR_WIDTH'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        beat_d = '0;
        cyc_d  = '0;
      end
    endcase
  end

  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = wdata_q[slice_idx*SRAM_WIDTH +: SRAM_WIDTH];
    ready     = 1'b1;
`ifdef SRAM_BYTE_MASK_EN
    beat_mask = mask_q[slice_idx*2 +: 2];
`endif
    case (state_q)
      IDLE: ready = ~(read_enable | write_enable);
      READ: begin
        ready     = 1'b0;
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
      end
      WRITE: begin
        ready     = 1'b0;
        SRAM_CE_N = 1'b0;
        dq_oe     = 1'b1;
        // WE_N rises on the beat's last cycle so data/address hold past the write edge.
`ifdef SRAM_BYTE_MASK_EN
        SRAM_UB_N = ~beat_mask[1];
        SRAM_LB_N = ~beat_mask[0];
        SRAM_WE_N = beat_end || (beat_mask == 2'b00);
`else
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        SRAM_WE_N = beat_end;
`endif
      end
      default: ready = 1'b1;
    endcase
    if (rst) ready = 1'b1;
  end

  assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_WIDTH{1'bz}};
  assign SRAM_ADDR = addr_q;
  assign read_data = rdata_q;
  assign done      = (state_q == DONE);

endmodule
